// File: rtl/absolute_value_arbiter.sv
// absolute_value_arbiter: round-robin sharing of one absolute_value magnitude
// unit between NUM_CH complex-sample requesters. Each accepted sample is
// tagged with its channel, and the tag travels alongside the unit's pipeline
// so the magnitude comes back as a one-cycle pulse naming its source channel.
module absolute_value_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int LATENCY    = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_CH-1:0]              reqValid,
  output logic [NUM_CH-1:0]              reqReady,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   reqRe,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   reqIm,
  output logic                           absEnable,
  output logic signed [DATA_WIDTH-1:0]   absRe,
  output logic signed [DATA_WIDTH-1:0]   absIm,
  input  logic signed [DATA_WIDTH:0]     absOut,
  output logic                           resValid,
  output logic [CH_W-1:0]                resChannel,
  output logic signed [DATA_WIDTH:0]     resData,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CH_W-1:0]       r_rrPtr;
  logic [LATENCY:0]      r_tagValid;
  logic [CH_W-1:0]       r_tagCh [LATENCY+1];
  logic                  r_absEnable;

  logic                  w_grantFound;
  logic [CH_W-1:0]       w_grantCh;
  logic                  w_transfer;
  logic                  w_anyTag;
  logic [DATA_WIDTH-1:0] w_selRe;
  logic [DATA_WIDTH-1:0] w_selIm;

  // Round-robin search: first requesting channel at or after the pointer, wrapping.
  always_comb begin
    logic [CH_W-1:0] w_idx;
    w_idx        = '0;
    w_grantFound = 1'b0;
    w_grantCh    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = r_rrPtr + CH_W'(i);
      if (!w_grantFound && reqValid[w_idx]) begin
        w_grantFound = 1'b1;
        w_grantCh    = w_idx;
      end
    end
  end

  assign w_transfer = (r_state == RUN) && enable && w_grantFound;
  assign w_anyTag   = |r_tagValid;
  assign w_selRe    = reqRe[w_grantCh*DATA_WIDTH +: DATA_WIDTH];
  assign w_selIm    = reqIm[w_grantCh*DATA_WIDTH +: DATA_WIDTH];

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // FSM next state: DRAIN lets accepted samples finish once enable drops.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (enable) w_nextState = RUN;
      RUN:     if (!enable) w_nextState = w_anyTag ? DRAIN : IDLE;
      DRAIN: begin
        if (enable)         w_nextState = RUN;
        else if (!w_anyTag) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: one-hot ready for the granted channel, busy outside IDLE.
  always_comb begin
    reqReady = '0;
    if (w_transfer) reqReady[w_grantCh] = 1'b1;
    busy = (r_state != IDLE);
  end

  // Pointer moves just past the channel that transferred, otherwise holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_rrPtr <= '0;
    else if (w_transfer) r_rrPtr <= w_grantCh + CH_W'(1);
  end

  // Issue register feeding the shared unit; zero on cycles with no transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      absRe <= '0;
      absIm <= '0;
    end else if (w_transfer) begin
      absRe <= w_selRe;
      absIm <= w_selIm;
    end else begin
      absRe <= '0;
      absIm <= '0;
    end
  end

  // Tag shift register; the last stage lines up with absOut.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tagValid <= '0;
      for (int i = 0; i <= LATENCY; i++) r_tagCh[i] <= '0;
    end else begin
      r_tagValid <= {r_tagValid[LATENCY-1:0], w_transfer};
      r_tagCh[0] <= w_grantCh;
      for (int i = 1; i <= LATENCY; i++) r_tagCh[i] <= r_tagCh[i-1];
    end
  end

  // Result capture: pulse with the aligned magnitude, hold data between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resValid   <= 1'b0;
      resChannel <= '0;
      resData    <= '0;
    end else if (r_tagValid[LATENCY]) begin
      resValid   <= 1'b1;
      resChannel <= r_tagCh[LATENCY];
      resData    <= absOut;
    end else begin
      resValid   <= 1'b0;
    end
  end

  // Unit enable rises on the first edge after reset and stays high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_absEnable <= 1'b0;
    else        r_absEnable <= 1'b1;
  end

  assign absEnable = r_absEnable;

endmodule

// File: tb/tb_absolute_value_arbiter.sv
// Testbench for absolute_value_arbiter. A behavioural two-stage magnitude unit
// stands in for absolute_value. The driver predicts each grant, pushes the
// expected result into a queue, and a negedge monitor pops and compares.
module tb_absolute_value_arbiter;

  localparam int DW  = 18;
  localparam int NCH = 4;
  localparam int CW  = 2;

  typedef struct {
    int ch;
    int mag;
    int cyc;
  } expT;

  logic                  clock;
  logic                  reset;
  logic                  enable;
  logic [NCH-1:0]        reqValid;
  logic [NCH-1:0]        reqReady;
  logic [NCH*DW-1:0]     reqRe;
  logic [NCH*DW-1:0]     reqIm;
  logic                  absEnable;
  logic signed [DW-1:0]  absRe;
  logic signed [DW-1:0]  absIm;
  logic signed [DW:0]    absOut;
  logic signed [DW:0]    absPipe;
  logic                  resValid;
  logic [CW-1:0]         resChannel;
  logic signed [DW:0]    resData;
  logic                  busy;

  logic signed [DW-1:0]  tbRe [NCH];
  logic signed [DW-1:0]  tbIm [NCH];
  int                    tbMag [NCH];
  logic signed [DW-1:0]  nxtRe [NCH];
  logic signed [DW-1:0]  nxtIm [NCH];
  int                    nxtMag [NCH];
  logic                  nxtEnable;

  expT sbQ[$];
  int  checkCnt = 0;
  int  errCnt = 0;
  int  cycleCnt = 0;
  int  tbPtr = 0;
  int  tbLastGrant = -1;

  absolute_value_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_CH(NCH),
    .CH_W(CW),
    .LATENCY(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqRe(reqRe),
    .reqIm(reqIm),
    .absEnable(absEnable),
    .absRe(absRe),
    .absIm(absIm),
    .absOut(absOut),
    .resValid(resValid),
    .resChannel(resChannel),
    .resData(resData),
    .busy(busy)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used to check result latency.
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Reference magnitude: max(|re|,|im|) + (min >> 2).
  function automatic int magRef(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    int a;
    int b;
    a = (re < 0) ? -int'(re) : int'(re);
    b = (im < 0) ? -int'(im) : int'(im);
    if (a >= b) return a + (b >> 2);
    else        return b + (a >> 2);
  endfunction

  // Stand-in for the shared absolute_value unit: two registered stages.
  always @(posedge clock) begin
    if (absEnable) begin
      absPipe <= (DW+1)'(magRef(absRe, absIm));
      absOut  <= absPipe;
    end
  end

  // Pack the per-channel samples onto the flat request buses.
  always_comb begin
    reqRe = '0;
    reqIm = '0;
    for (int k = 0; k < NCH; k++) begin
      reqRe[k*DW +: DW] = tbRe[k];
      reqIm[k*DW +: DW] = tbIm[k];
    end
  end

  // Single comparison with pass/fail bookkeeping.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Stage a sample for channel k; it reaches the bus at the next driven cycle.
  task automatic setSample(input int k, input int re, input int im, input int mag);
    nxtRe[k]  = DW'(re);
    nxtIm[k]  = DW'(im);
    nxtMag[k] = mag;
  endtask

  // One cycle: drive requests just after the edge, predict the grant,
  // compare reqReady mid-cycle and queue the expected result of any transfer.
  task automatic applyStimulus(input logic [NCH-1:0] v, input bit expectGrant);
    int expReady;
    int grant;
    int k;
    @(posedge clock);
    #1;
    for (int c = 0; c < NCH; c++) begin
      tbRe[c]  = nxtRe[c];
      tbIm[c]  = nxtIm[c];
      tbMag[c] = nxtMag[c];
    end
    enable   = nxtEnable;
    reqValid = v;
    #3;
    expReady = 0;
    grant    = -1;
    if (expectGrant) begin
      for (int i = 0; i < NCH; i++) begin
        k = (tbPtr + i) % NCH;
        if (grant < 0 && v[k]) grant = k;
      end
    end
    if (grant >= 0) expReady = 1 << grant;
    checkOutput("reqReady", int'(reqReady), expReady);
    if (grant >= 0) begin
      sbQ.push_back('{ch: grant, mag: tbMag[grant], cyc: cycleCnt + 4});
      tbPtr = (grant + 1) % NCH;
    end
    tbLastGrant = grant;
  endtask

  // Idle until every queued result has been seen, with a bounded wait.
  task automatic waitDrain();
    for (int i = 0; i < 20 && sbQ.size() != 0; i++) applyStimulus('0, 1'b1);
    checkOutput("drainQueueEmpty", sbQ.size(), 0);
  endtask

  // Every output must read its reset value.
  task automatic checkResetOutputs();
    checkOutput("rst.reqReady", int'(reqReady), 0);
    checkOutput("rst.absEnable", int'(absEnable), 0);
    checkOutput("rst.absRe", int'(absRe), 0);
    checkOutput("rst.absIm", int'(absIm), 0);
    checkOutput("rst.resValid", int'(resValid), 0);
    checkOutput("rst.resChannel", int'(resChannel), 0);
    checkOutput("rst.resData", int'(resData), 0);
    checkOutput("rst.busy", int'(busy), 0);
  endtask

  // Monitor: each result pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    expT e;
    if (reset && resValid) begin
      if (sbQ.size() == 0) begin
        checkCnt++;
        errCnt++;
        $display("[TB] FAIL unexpectedResult: got channel %0d data %0d, expected no pulse (cycle %0d)",
                 resChannel, resData, cycleCnt);
      end else begin
        e = sbQ.pop_front();
        checkOutput("resChannel", int'(resChannel), e.ch);
        checkOutput("resData", int'(resData), e.mag);
        checkOutput("resLatency", cycleCnt, e.cyc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomised soak.
  initial begin
    logic [NCH-1:0] hold;
    logic [NCH-1:0] v;
    reset     = 1'b0;
    enable    = 1'b0;
    nxtEnable = 1'b0;
    reqValid  = '0;
    for (int c = 0; c < NCH; c++) begin
      tbRe[c] = '0;  tbIm[c] = '0;  tbMag[c] = 0;
      nxtRe[c] = '0; nxtIm[c] = '0; nxtMag[c] = 0;
    end
    #3;
    checkResetOutputs();
    #9;
    reset = 1'b1;

    // Single sample; the IDLE->RUN cycle must not grant.
    setSample(1, 59, 15683, 15697);
    nxtEnable = 1'b1;
    applyStimulus(4'b0010, 1'b0);
    checkOutput("absEnableAfterRelease", int'(absEnable), 1);
    applyStimulus(4'b0010, 1'b1);
    waitDrain();
    repeat (3) applyStimulus('0, 1'b1);

    // Move the pointer back to 0 with a single ch3 request.
    setSample(3, 12, -78, 81);
    applyStimulus(4'b1000, 1'b1);
    waitDrain();

    // Full contention from pointer 0.
    setSample(0, -131000, 69420, 148355);
    setSample(1, 0, -123, 123);
    setSample(2, -123456, -123456, 154320);
    setSample(3, 12, -78, 81);
    repeat (8) applyStimulus(4'b1111, 1'b1);
    waitDrain();

    // Wrap and skip: pointer to 1, then only ch3 and ch0 request.
    setSample(0, 131071, 0, 131071);
    setSample(3, -131072, -131072, 163840);
    applyStimulus(4'b0001, 1'b1);
    repeat (4) applyStimulus(4'b1001, 1'b1);
    waitDrain();

    // Enable drop with three samples in flight.
    setSample(1, 1000, -2000, 2250);
    setSample(2, -7, 7, 8);
    setSample(3, 400, 40, 410);
    repeat (3) applyStimulus(4'b1110, 1'b1);
    nxtEnable = 1'b0;
    repeat (4) begin
      applyStimulus(4'b1110, 1'b0);
      checkOutput("busyDuringDrain", int'(busy), 1);
    end
    repeat (4) begin
      applyStimulus(4'b1110, 1'b0);
      checkOutput("busyAfterDrain", int'(busy), 0);
    end
    checkOutput("enableDropResults", sbQ.size(), 0);

    // Re-enable, then reset with two samples in flight.
    setSample(0, 5, 3, 5);
    setSample(1, -9, 20, 22);
    nxtEnable = 1'b1;
    applyStimulus(4'b0011, 1'b0);
    repeat (2) applyStimulus(4'b0011, 1'b1);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    reqValid = '0;
    #3;
    checkResetOutputs();
    sbQ.delete();
    tbPtr = 0;
    @(posedge clock);
    #4;
    checkResetOutputs();
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (8) applyStimulus('0, 1'b1);

    // Randomised soak; a waiting requester keeps its data stable.
    hold = '0;
    for (int n = 0; n < 300; n++) begin
      v = hold;
      for (int c = 0; c < NCH; c++) begin
        if (!hold[c] && ($urandom_range(0, 1) == 1)) begin
          logic signed [DW-1:0] r;
          logic signed [DW-1:0] m;
          r = DW'($urandom);
          m = DW'($urandom);
          setSample(c, int'(r), int'(m), magRef(r, m));
          v[c] = 1'b1;
        end
      end
      applyStimulus(v, 1'b1);
      hold = v;
      if (tbLastGrant >= 0) hold[tbLastGrant] = 1'b0;
    end
    waitDrain();
    repeat (4) applyStimulus('0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/absolute_value_arbiter.md
# absolute_value_arbiter

Round-robin arbiter that shares one `absolute_value` magnitude unit (|re|,|im| → max + min>>2, 2-cycle latency) between `NUM_CH` sample requesters. It accepts complex samples over per-channel valid/ready handshakes and issues at most one sample per cycle to the unit. It tags each in-flight sample with its channel and returns each magnitude as a one-cycle result pulse carrying the channel number. It sits between the per-channel sample sources and the single `absolute_value` instance in the detection path.

## Interface
- `DATA_WIDTH`, 18, width of each signed real/imag input sample.
- `NUM_CH`, 4, number of requesters; a power of 2, at least 2.
- `CH_W`, $clog2(NUM_CH), channel-index width.
- `LATENCY`, 2, cycles from `absRe`/`absIm` presented to the matching `absOut`.

Ports:
- `clock`  in  1  system clock; all logic is on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new grants; low = finish in-flight work, accept nothing new.
- `reqValid`  in  NUM_CH  per-channel sample valid.
- `reqReady`  out  NUM_CH  per-channel accept, one-hot or zero.
- `reqRe`  in  NUM_CH*DATA_WIDTH  packed signed real parts; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `reqIm`  in  NUM_CH*DATA_WIDTH  packed signed imag parts, same packing.
- `absEnable`  out  1  enable to the shared `absolute_value`.
- `absRe`  out  DATA_WIDTH  registered real part to the unit.
- `absIm`  out  DATA_WIDTH  registered imag part to the unit.
- `absOut`  in  DATA_WIDTH+1  magnitude from the unit.
- `resValid`  out  1  one-cycle result strobe.
- `resChannel`  out  CH_W  source channel of `resData`.
- `resData`  out  DATA_WIDTH+1  magnitude; signed type, always non-negative.
- `busy`  out  1  high while the FSM is not IDLE.

## Operation
- **Grant.**
  - Eligible only when FSM is RUN and `enable`=1.
  - Grant goes to the first k with `reqValid[k]`=1, searching from `rrPtr` upward and wrapping modulo NUM_CH.
  - `reqReady[k]`=1 combinationally for that k only.
  - A transfer occurs on a cycle with `reqValid[k]` & `reqReady[k]`.
- **Pointer.** On a transfer from channel g, `rrPtr` ← (g+1) mod NUM_CH. With no transfer, `rrPtr` holds.
- **Issue.**
  - On a transfer, the next edge registers `absRe`/`absIm` ← channel g's sample.
  - Otherwise `absRe`/`absIm` ← 0.
- **Tag pipeline.**
  - Shift register of depth LATENCY+1, each stage holding {valid, channel}.
  - Stage 0 loads {transfer, g} on each edge.
  - The tag emerging at depth LATENCY is aligned with `absOut`.
- **Result.**
  - When the aligned tag is valid, the next edge sets `resData` ← `absOut`, `resChannel` ← tag channel, `resValid` ← 1.
  - Otherwise `resValid` ← 0, and `resData`/`resChannel` hold.
  - There is no result backpressure; consumers must take every pulse.
- **absEnable.** Registered: 0 in reset, 1 from the first edge after reset release, then constant.
- **FSM.**
  - IDLE → RUN when `enable`=1.
  - RUN → DRAIN when `enable`=0 and any tag is valid.
  - RUN → IDLE when `enable`=0 and no tag is valid.
  - DRAIN → IDLE when no tag is valid.
  - DRAIN → RUN when `enable`=1.
- **Width.** `resData` passes `absOut` through unmodified; no saturation or truncation.

## Timing
- Reset values:
  - outputs: `reqReady`=0, `absEnable`=0, `absRe`=`absIm`=0, `resValid`=0, `resChannel`=0, `resData`=0, `busy`=0;
  - internal: `rrPtr`=0, all tags invalid, FSM IDLE.
- Latency: a transfer in cycle a gives `absRe`/`absIm` in a+1, `absOut` in a+1+LATENCY, and `resValid` in a+2+LATENCY (cycle a+4 at the default).
- Throughput is one sample per cycle. Results return in grant order, and a channel's results never reorder.
- `reqReady` is high in the first RUN cycle; the IDLE→RUN edge itself grants nothing.
- `enable` falling: no grant in any cycle where `enable`=0. Every already-accepted sample still produces its `resValid`.
- Reset asserted mid-operation:
  - in-flight tags are discarded and outputs go to reset values immediately;
  - no stale `resValid` appears after release.
- A requester holding `reqValid` while not granted must keep its data stable; the arbiter ignores its data until the grant.
- `reqValid` dropping before grant is legal, and no transfer occurs for it.

## Test plan
- **Single sample:** ch1 sends (59, 15683) once with `enable`=1. Required: `resValid` exactly 4 cycles after the transfer, `resData`=15697, `resChannel`=1, and no further pulses.
- **Full contention:** all 4 channels hold `reqValid`=1 from `rrPtr`=0 with a constant sample each:
  - ch0 (-131000, 69420)→148355;
  - ch1 (0, -123)→123;
  - ch2 (-123456, -123456)→154320;
  - ch3 (12, -78)→81.
  Required: grants 0,1,2,3,0,… one per cycle, and results in matching channel order back-to-back.
- **Wrap and skip:** only ch3 and ch0 request, with `rrPtr`=1. Required: grant order 3,0,3,0, and ch1/ch2 `reqReady` never high.
- **Enable drop:** deassert `enable` with 3 samples in flight. Required: `busy` stays high through DRAIN, all 3 results emerge, then `busy`=0 and `reqReady` stays 0.
- **Reset mid-run:** pulse `reset` low with 2 samples in flight. Required: all outputs read 0 during reset, and no `resValid` appears for those samples after release.
- **Randomised soak:** random `reqValid` on every channel. Required: every accepted sample yields exactly one result equal to max(|re|,|im|)+(min>>2) with the correct channel, in per-channel order.
